// File: rtl/sal_bk_req_queue.sv
// rtl/sal_bk_req_queue.sv - per-bank request FIFO with row-hit and pending-write lookahead
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 8
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 16
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif

module sal_bk_req_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = `AXI_ID_WIDTH,
  parameter int LEN_W = `AXI_LEN_WIDTH,
  parameter int RA_W  = `DRAM_RA_WIDTH,
  parameter int CA_W  = `DRAM_CA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ID_W-1:0]          in_id,
  input  logic [RA_W-1:0]          in_ra,
  input  logic [CA_W-1:0]          in_ca,
  input  logic [LEN_W-1:0]         in_len,
  input  logic                     in_wr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          out_id,
  output logic [RA_W-1:0]          out_ra,
  output logic [CA_W-1:0]          out_ca,
  output logic [LEN_W-1:0]         out_len,
  output logic                     out_wr,
  output logic                     next_row_hit,
  output logic [$clog2(DEPTH):0]   wr_pending_cnt,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ID_W-1:0]  r_id  [DEPTH];
  logic [RA_W-1:0]  r_ra  [DEPTH];
  logic [CA_W-1:0]  r_ca  [DEPTH];
  logic [LEN_W-1:0] r_len [DEPTH];
  logic             r_wr  [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_wr_cnt;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_nxt;

  // in_ready looks only at state, so a full queue never accepts in the cycle it pops
  assign in_ready  = (r_occ != FULL_CNT);
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_rd_nxt  = r_rd_ptr + PTR_W'(1);

  assign out_id  = r_id[r_rd_ptr];
  assign out_ra  = r_ra[r_rd_ptr];
  assign out_ca  = r_ca[r_rd_ptr];
  assign out_len = r_len[r_rd_ptr];
  assign out_wr  = r_wr[r_rd_ptr];

  assign next_row_hit   = (r_occ >= CNT_W'(2)) && (r_ra[w_rd_nxt] == r_ra[r_rd_ptr]);
  assign occupancy      = r_occ;
  assign wr_pending_cnt = r_wr_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id[r_wr_ptr]  <= in_id;
      r_ra[r_wr_ptr]  <= in_ra;
      r_ca[r_wr_ptr]  <= in_ca;
      r_len[r_wr_ptr] <= in_len;
      r_wr[r_wr_ptr]  <= in_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
      case ({w_push & in_wr, w_pop & out_wr})
        2'b10:   r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        2'b01:   r_wr_cnt <= r_wr_cnt - CNT_W'(1);
        default: r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_occ <= FULL_CNT);
      assert (r_wr_cnt <= r_occ);
      if (!$past(rst) && !$past(w_push)) assert (r_wr_ptr == $past(r_wr_ptr));
      if (!$past(rst) && !$past(w_pop))  assert (r_rd_ptr == $past(r_rd_ptr));
    end
  end

endmodule

// File: tb/tb_sal_bk_req_queue.sv
// tb/tb_sal_bk_req_queue.sv - table-driven scoreboard bench for sal_bk_req_queue
module tb_sal_bk_req_queue;
  localparam int DEPTH = 4;
  localparam int ID_W  = 8;
  localparam int LEN_W = 8;
  localparam int RA_W  = 16;
  localparam int CA_W  = 10;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [RA_W-1:0]  ra;
    logic [CA_W-1:0]  ca;
    logic [LEN_W-1:0] len;
    logic             wr;
  } req_t;

  typedef struct {
    logic v;
    logic r;
    req_t q;
    int   e_occ;
    int   e_wr;
    logic e_nrh;
    logic e_ir;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ID_W-1:0]  in_id;
  logic [RA_W-1:0]  in_ra;
  logic [CA_W-1:0]  in_ca;
  logic [LEN_W-1:0] in_len;
  logic             in_wr;
  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic [RA_W-1:0]  out_ra;
  logic [CA_W-1:0]  out_ca;
  logic [LEN_W-1:0] out_len;
  logic             out_wr;
  logic             next_row_hit;
  logic [CNT_W-1:0] wr_pending_cnt;
  logic [CNT_W-1:0] occupancy;

  int   n_pass  = 0;
  int   n_total = 0;
  req_t sb[$];
  vec_t vecs[$];

  sal_bk_req_queue #(
    .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W), .RA_W(RA_W), .CA_W(CA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_ra(in_ra), .in_ca(in_ca), .in_len(in_len), .in_wr(in_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_ra(out_ra), .out_ca(out_ca), .out_len(out_len), .out_wr(out_wr),
    .next_row_hit(next_row_hit), .wr_pending_cnt(wr_pending_cnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic v, input logic r, input int id, input int ra,
                              input int ca, input int len, input logic wr,
                              input int e_occ, input int e_wr, input logic e_nrh, input logic e_ir);
    vec_t t;
    t.v = v; t.r = r;
    t.q.id = ID_W'(id); t.q.ra = RA_W'(ra); t.q.ca = CA_W'(ca);
    t.q.len = LEN_W'(len); t.q.wr = wr;
    t.e_occ = e_occ; t.e_wr = e_wr; t.e_nrh = e_nrh; t.e_ir = e_ir;
    return t;
  endfunction

  // Checks combinational outputs against the scoreboard, clocks once, then updates it.
  task automatic cycle(input logic v, input logic r, input req_t q);
    int   wcnt;
    logic exp_nrh;
    bit   do_push;
    bit   do_pop;
    in_valid = v; out_ready = r;
    in_id = q.id; in_ra = q.ra; in_ca = q.ca; in_len = q.len; in_wr = q.wr;
    #1;
    wcnt = 0;
    foreach (sb[i]) if (sb[i].wr) wcnt++;
    exp_nrh = 1'b0;
    if (sb.size() >= 2) exp_nrh = (sb[1].ra == sb[0].ra);
    chk("occupancy_pre", 32'(occupancy), 32'(sb.size()));
    chk("wr_pending_pre", 32'(wr_pending_cnt), 32'(wcnt));
    chk("in_ready_pre", 32'(in_ready), 32'(sb.size() < DEPTH));
    chk("out_valid_pre", 32'(out_valid), 32'(sb.size() != 0));
    chk("next_row_hit_pre", 32'(next_row_hit), 32'(exp_nrh));
    if (sb.size() != 0) begin
      chk("out_id", 32'(out_id), 32'(sb[0].id));
      chk("out_ra", 32'(out_ra), 32'(sb[0].ra));
      chk("out_ca", 32'(out_ca), 32'(sb[0].ca));
      chk("out_len", 32'(out_len), 32'(sb[0].len));
      chk("out_wr", 32'(out_wr), 32'(sb[0].wr));
    end
    do_pop  = r && (sb.size() != 0);
    do_push = v && (sb.size() < DEPTH);
    @(posedge clk);
    #1;
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back(q);
  endtask

  initial begin
    req_t idle;
    req_t r7;
    idle = '{id: '0, ra: '0, ca: '0, len: '0, wr: 1'b0};

    vecs.push_back(mk(1, 0,  3, 'h12,  8, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0,  0, 'h20,  0, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0,  1, 'h21,  1, 2, 0, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0,  2, 'h22,  2, 2, 0, 3, 0, 0, 1));
    vecs.push_back(mk(1, 0,  3, 'h23,  3, 2, 0, 4, 0, 0, 0));
    vecs.push_back(mk(1, 0,  4, 'h24,  4, 2, 0, 4, 0, 0, 0));
    vecs.push_back(mk(1, 1,  5, 'h25,  5, 2, 0, 3, 0, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 2, 0, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0,  8, 'h30,  8, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1,  9, 'h31,  9, 2, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 10, 'h40, 10, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 11, 'h40, 11, 2, 0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 0, 12, 'h41, 12, 2, 0, 3, 0, 1, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 2, 0, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1,  0,    0,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 13, 'h50, 13, 2, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 14, 'h51, 14, 2, 0, 2, 1, 0, 1));
    vecs.push_back(mk(1, 0, 15, 'h52, 15, 2, 1, 3, 2, 0, 1));
    vecs.push_back(mk(1, 1, 16, 'h53, 16, 2, 1, 3, 2, 0, 1));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_id = '0; in_ra = '0; in_ca = '0; in_len = '0; in_wr = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_wr_pending", 32'(wr_pending_cnt), 32'd0);
    chk("rst_next_row_hit", 32'(next_row_hit), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].r, vecs[i].q);
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("v%0d_wr_pending", i), 32'(wr_pending_cnt), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_next_row_hit", i), 32'(next_row_hit), 32'(vecs[i].e_nrh));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
    end

    // Three entries are queued here; reset lands between clock edges.
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_wr_pending", 32'(wr_pending_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_next_row_hit", 32'(next_row_hit), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    r7 = '{id: ID_W'(7), ra: RA_W'('h77), ca: CA_W'(7), len: LEN_W'(3), wr: 1'b0};
    cycle(1'b1, 1'b0, r7);
    chk("post_rst_occupancy", 32'(occupancy), 32'd1);
    chk("post_rst_head_id", 32'(out_id), 32'd7);
    cycle(1'b0, 1'b1, idle);
    cycle(1'b0, 1'b1, idle);
    chk("final_occupancy", 32'(occupancy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
